ln_token_sequencer: RTL
=======================

// Module: ln_token_sequencer
// PURPOSE
//  Initiator that drives the LayerNorm core over a run of tokens. Accepts a host command
//  (input base, output base, count), fetches each D-element token vector from the input
//  buffer, pulses the core's start, waits for its out_valid, and writes the normalised
//  vector to the output buffer. Sits between the activation SRAMs and the LayerNorm top.
// PARAMETERS
//  D        4    elements per token vector
//  DW       8    signed input element width
//  OUT_W    17   signed output element width (DW+FRAC_W+1, FRAC_W=8)
//  ADDR_W   10   buffer word-address width (one word = one token)
//  CNT_W    8    token-count width
//  TIMEOUT  64   max cycles waiting for ln_out_valid before abort
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous reset, active-high
//  cmd_valid     in   1          host command valid
//  cmd_ready     out  1          high only in IDLE
//  cmd_base_in   in   ADDR_W     first input-buffer word
//  cmd_base_out  in   ADDR_W     first output-buffer word
//  cmd_count     in   CNT_W      tokens to process
//  busy          out  1          high from command accept until done pulse
//  done          out  1          one-cycle pulse at end of run (normal or aborted)
//  err_timeout   out  1          sticky; set on abort, cleared on next accepted command
//  rd_en         out  1          input-buffer read strobe
//  rd_addr       out  ADDR_W     input-buffer address
//  rd_data       in   D*DW       token vector, valid the cycle after rd_en
//  ln_start      out  1          one-cycle start pulse to LayerNorm core
//  ln_x          out  D*DW       token vector to core; element i at [i*DW +: DW]
//  ln_out_valid  in   1          core result pulse
//  ln_y          in   D*OUT_W    core result, sampled when ln_out_valid=1
//  wr_en         out  1          output-buffer write strobe
//  wr_addr       out  ADDR_W     output-buffer address
//  wr_data       out  D*OUT_W    normalised vector
// BEHAVIOUR
//  Reset: all outputs 0, except cmd_ready=1. ln_x, counters and captured y are cleared;
//   state IDLE. Reset mid-run abandons the run with no done pulse.
//  FSM: IDLE -> FETCH -> WAIT_RD -> START -> WAIT_LN -> WRITE -> (FETCH | DONE) -> IDLE.
//   IDLE: on cmd_valid&cmd_ready, latch bases and count, clear err_timeout, busy=1.
//     count==0 goes to DONE directly, with no memory or core traffic.
//   FETCH: rd_en=1, rd_addr=base_in+idx. WAIT_RD: rd_data registered into ln_x.
//   START: ln_start=1 for exactly one cycle. ln_x holds stable from START until WRITE,
//     because the core samples x over several cycles.
//   WAIT_LN: the watchdog counts cycles. ln_out_valid=1 latches ln_y and moves to WRITE.
//     If the counter reaches TIMEOUT first, set err_timeout and go to DONE.
//     When ln_out_valid and timeout expiry coincide, ln_out_valid wins.
//   WRITE: wr_en=1, wr_addr=base_out+idx, wr_data=latched y; idx++.
//     Goes to DONE if idx+1==count, else FETCH.
//   DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
//  Per token: 4 cycles + core latency L (START to out_valid).
//  Gap from ln_out_valid to the next ln_start is >=4 cycles. This covers the core's
//   DONE->IDLE recovery.
//  Addresses wrap modulo 2^ADDR_W. ln_out_valid outside WAIT_LN is ignored.
//  cmd_valid while busy is not accepted (cmd_ready=0); the host holds it.
// STRUCTURE
//  Package ln_seq_pkg holds:
//   - state_t enum {S_IDLE,S_FETCH,S_WAIT_RD,S_START,S_WAIT_LN,S_WRITE,S_DONE};
//   - localparams X_W=D*DW and Y_W=D*OUT_W.
//  Sub-module ln_seq_watchdog holds the $clog2(TIMEOUT+1)-bit counter.
//   Ports: clr, en, expired.
//  FSM, address/index counters and the data registers stay in this module.
// TESTING
//  Bench model: core responds after a configurable latency L; SRAMs are behavioural with
//   1-cycle read latency.
//  1 count=1, base_in=0, L=6, x={1,2,3,4}: one rd_en, one ln_start 3 cycles after accept,
//    wr_en at addr base_out one cycle after out_valid carrying the model's y, done 1 cycle after wr_en.
//  2 count=5, L=3: 5 writes at base_out..base_out+4, in order; ln_x stable from each start
//    through out_valid; start-to-start spacing = L+4.
//  3 count=0: done pulses within 2 cycles of accept; no rd_en, ln_start or wr_en.
//  4 Model never responds: err_timeout=1 and done after TIMEOUT cycles in WAIT_LN, no wr_en.
//    The next command clears err_timeout.
//  5 base_in=1022, count=4, ADDR_W=10: rd_addr sequence 1022,1023,0,1. Spurious out_valid
//    during FETCH produces no write.
//  6 rst asserted in WAIT_LN: next cycle all outputs 0, cmd_ready=1, no done; a new command
//    then completes normally.

Source files
------------

// File: rtl/ln_seq_pkg.sv
// Shared types and default sizing for the LayerNorm token sequencer.
// The FSM state encoding lives here so the checker and bench can refer to it.
package ln_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_START   = 3'd3,
        S_WAIT_LN = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam int SEQ_D     = 4;
    localparam int SEQ_DW    = 8;
    localparam int SEQ_OUT_W = 17;
    localparam int X_W       = SEQ_D * SEQ_DW;
    localparam int Y_W       = SEQ_D * SEQ_OUT_W;

endpackage

// File: rtl/ln_seq_watchdog.sv
// Cycle counter guarding the wait for the LayerNorm core's result.
// expired rises on the TIMEOUT-th consecutive enabled cycle.
module ln_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] cnt_r;

    // Saturating wait counter, restarted whenever the sequencer leaves the wait state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WD_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {WD_W{1'b0}};
        end else if (en && (cnt_r != WD_W'(TIMEOUT))) begin
            cnt_r <= cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && (cnt_r >= WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/ln_token_sequencer.sv
// Drives the LayerNorm core over a run of tokens: fetch vector, start core,
// wait for the result (with watchdog), write it back, repeat.
module ln_token_sequencer
    import ln_seq_pkg::*;
#(
    parameter int D       = SEQ_D,
    parameter int DW      = SEQ_DW,
    parameter int OUT_W   = SEQ_OUT_W,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_base_in,
    input  logic [ADDR_W-1:0]    cmd_base_out,
    input  logic [CNT_W-1:0]     cmd_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [D*DW-1:0]      rd_data,
    output logic                 ln_start,
    output logic [D*DW-1:0]      ln_x,
    input  logic                 ln_out_valid,
    input  logic [D*OUT_W-1:0]   ln_y,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [D*OUT_W-1:0]   wr_data
);

    localparam int XW = D * DW;
    localparam int YW = D * OUT_W;

    state_t              state_r;
    state_t              state_nx_s;
    logic                accept_s;
    logic                last_s;
    logic                wd_clr_s;
    logic                wd_en_s;
    logic                wd_expired_s;
    logic [CNT_W-1:0]    idx_r;
    logic [CNT_W-1:0]    idx_nx_s;
    logic [CNT_W-1:0]    count_r;
    logic [ADDR_W-1:0]   base_in_r;
    logic [ADDR_W-1:0]   base_in_nx_s;
    logic [ADDR_W-1:0]   base_out_r;

    logic                cmd_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                err_timeout_r;
    logic                rd_en_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                ln_start_r;
    logic [XW-1:0]       ln_x_r;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [YW-1:0]       y_r;

    // cmd_ready is only ever high in IDLE, so this is an IDLE-only accept
    assign accept_s = cmd_valid && cmd_ready_r;
    assign wd_en_s  = (state_r == S_WAIT_LN);
    assign wd_clr_s = !wd_en_s;

    ln_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // Next-state logic plus look-ahead of index and input base for the registered address
    always_comb begin
        state_nx_s   = state_r;
        idx_nx_s     = idx_r;
        base_in_nx_s = base_in_r;
        last_s       = (({1'b0, idx_r} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, count_r});
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    base_in_nx_s = cmd_base_in;
                    idx_nx_s     = {CNT_W{1'b0}};
                    if (cmd_count == {CNT_W{1'b0}}) begin
                        state_nx_s = S_DONE;
                    end else begin
                        state_nx_s = S_FETCH;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_FETCH:   state_nx_s = S_WAIT_RD;
            S_WAIT_RD: state_nx_s = S_START;
            S_START:   state_nx_s = S_WAIT_LN;
            S_WAIT_LN: begin
                // A result arriving on the expiry cycle still counts
                if (ln_out_valid) begin
                    state_nx_s = S_WRITE;
                end else if (wd_expired_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_WAIT_LN;
                end
            end
            S_WRITE: begin
                idx_nx_s = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (last_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered handshake and strobe outputs, decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_timeout_r <= 1'b0;
            rd_en_r       <= 1'b0;
            rd_addr_r     <= {ADDR_W{1'b0}};
            ln_start_r    <= 1'b0;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= {ADDR_W{1'b0}};
        end else begin
            cmd_ready_r <= (state_nx_s == S_IDLE);
            busy_r      <= (state_nx_s != S_IDLE);
            done_r      <= (state_nx_s == S_DONE);
            rd_en_r     <= (state_nx_s == S_FETCH);
            ln_start_r  <= (state_nx_s == S_START);
            wr_en_r     <= (state_nx_s == S_WRITE);
            if (state_nx_s == S_FETCH) begin
                rd_addr_r <= base_in_nx_s + ADDR_W'(idx_nx_s);
            end else begin
                rd_addr_r <= rd_addr_r;
            end
            if (state_nx_s == S_WRITE) begin
                wr_addr_r <= base_out_r + ADDR_W'(idx_r);
            end else begin
                wr_addr_r <= wr_addr_r;
            end
            if (accept_s) begin
                err_timeout_r <= 1'b0;
            end else if (wd_en_s && !ln_out_valid && wd_expired_s) begin
                err_timeout_r <= 1'b1;
            end else begin
                err_timeout_r <= err_timeout_r;
            end
        end
    end

    // Command latches, token index and the vector/result data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r      <= {CNT_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            base_in_r  <= {ADDR_W{1'b0}};
            base_out_r <= {ADDR_W{1'b0}};
            ln_x_r     <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
        end else begin
            idx_r     <= idx_nx_s;
            base_in_r <= base_in_nx_s;
            if (accept_s) begin
                count_r    <= cmd_count;
                base_out_r <= cmd_base_out;
            end else begin
                count_r    <= count_r;
                base_out_r <= base_out_r;
            end
            // ln_x is only reloaded here, so it stays put while the core samples it
            if (state_r == S_WAIT_RD) begin
                ln_x_r <= rd_data;
            end else begin
                ln_x_r <= ln_x_r;
            end
            if (wd_en_s && ln_out_valid) begin
                y_r <= ln_y;
            end else begin
                y_r <= y_r;
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_timeout = err_timeout_r;
    assign rd_en       = rd_en_r;
    assign rd_addr     = rd_addr_r;
    assign ln_start    = ln_start_r;
    assign ln_x        = ln_x_r;
    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = y_r;

endmodule
